// File: rtl/sw_entry_ctrl.sv
// sw_entry_ctrl: debounced slide-switch code entry, password check, fail lockout.
// Define ENTRY_TIMEOUT_EN to abandon a partial entry after TIMEOUT_CYC idle clocks.
module sw_entry_ctrl #(
    parameter int          BYTE         = 4,
    parameter int          DEBOUNCE_CYC = 16,
    parameter logic [27:0] PASSWORD     = 28'h0001234,
    parameter int          MAX_FAIL     = 3,
    parameter int          LOCK_CYC     = 64,
    parameter int          TIMEOUT_CYC  = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [9:0]        sw,
    input  logic              clr,
    output logic [4*BYTE-1:0] code,
    output logic [2:0]        code_cnt,
    output logic              digit_valid,
    output logic              multi_err,
    output logic              unlock,
    output logic              fail,
    output logic              locked,
    output logic              timeout,
    output logic [2:0]        state
);
    localparam int CW = 4 * BYTE;
    localparam int DW = $clog2(DEBOUNCE_CYC);
    localparam int FW = $clog2(MAX_FAIL + 1);
    localparam int LW = $clog2(LOCK_CYC + 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ENTRY = 3'd1,
        CHECK = 3'd2,
        OPEN  = 3'd3,
        LOCK  = 3'd4
    } state_t;

    if (BYTE < 1 || BYTE > 7 || DEBOUNCE_CYC < 2 || MAX_FAIL < 1 || LOCK_CYC < 1 || TIMEOUT_CYC < 1) begin : g_bad_param
        $error("sw_entry_ctrl: parameter out of range");
    end

    logic [9:0]    sync1_q, sync2_q, stable_q, old_q, rise;
    logic [DW-1:0] db_cnt_q;
    logic          db_done, multi, one_hot, accept, to_hit;
    logic [3:0]    digit;
    state_t        state_q;
    logic [CW-1:0] code_q;
    logic [2:0]    code_cnt_q;
    logic [FW-1:0] fail_cnt_q;
    logic [LW-1:0] lock_cnt_q;
    logic          digit_valid_q, multi_err_q, fail_q, timeout_q;

    // sync1 acts as a one-cycle lookahead so a pending change restarts the count early
    assign db_done = db_cnt_q == DW'(DEBOUNCE_CYC - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            db_cnt_q <= '0;
            stable_q <= '0;
            old_q    <= '0;
        end else begin
            sync1_q  <= sw;
            sync2_q  <= sync1_q;
            old_q    <= stable_q;
            db_cnt_q <= (sync1_q != sync2_q) ? '0 : (db_done ? db_cnt_q : db_cnt_q + DW'(1));
            if (sync1_q == sync2_q && db_done) stable_q <= sync2_q;
        end
    end

    assign rise    = stable_q & ~old_q;
    assign multi   = (rise & (rise - 10'd1)) != '0;
    assign one_hot = rise != '0 && !multi;
    assign accept  = (state_q == IDLE || state_q == ENTRY) && !clr && one_hot;

    always_comb begin
        digit = '0;
        for (int i = 0; i < 10; i++) if (rise[i]) digit = 4'(i);
    end

`ifdef ENTRY_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] to_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) to_cnt_q <= '0;
        else        to_cnt_q <= (state_q != ENTRY || accept) ? '0 : to_cnt_q + TW'(1);
    end

    assign to_hit = state_q == ENTRY && to_cnt_q == TW'(TIMEOUT_CYC - 1);
`else
    assign to_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            code_q        <= '0;
            code_cnt_q    <= '0;
            fail_cnt_q    <= '0;
            lock_cnt_q    <= '0;
            digit_valid_q <= 1'b0;
            multi_err_q   <= 1'b0;
            fail_q        <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            digit_valid_q <= 1'b0;
            fail_q        <= 1'b0;
            timeout_q     <= 1'b0;
            multi_err_q   <= multi;
            case (state_q)
                IDLE, ENTRY: begin
                    if (clr) begin
                        state_q    <= IDLE;
                        code_q     <= '0;
                        code_cnt_q <= '0;
                    end else if (accept) begin
                        code_q        <= CW'({code_q, digit});
                        code_cnt_q    <= code_cnt_q + 3'd1;
                        digit_valid_q <= 1'b1;
                        state_q       <= (code_cnt_q == 3'(BYTE - 1)) ? CHECK : ENTRY;
                    end else if (to_hit) begin
                        timeout_q  <= 1'b1;
                        state_q    <= IDLE;
                        code_q     <= '0;
                        code_cnt_q <= '0;
                    end
                end
                CHECK: begin
                    if (code_q == PASSWORD[CW-1:0]) begin
                        state_q    <= OPEN;
                        fail_cnt_q <= '0;
                    end else begin
                        fail_q     <= 1'b1;
                        fail_cnt_q <= fail_cnt_q + FW'(1);
                        code_q     <= '0;
                        code_cnt_q <= '0;
                        lock_cnt_q <= '0;
                        state_q    <= (fail_cnt_q == FW'(MAX_FAIL - 1)) ? LOCK : IDLE;
                    end
                end
                OPEN: begin
                    if (clr) begin
                        state_q    <= IDLE;
                        code_q     <= '0;
                        code_cnt_q <= '0;
                    end
                end
                LOCK: begin
                    lock_cnt_q <= lock_cnt_q + LW'(1);
                    if (lock_cnt_q == LW'(LOCK_CYC - 1)) begin
                        state_q    <= IDLE;
                        fail_cnt_q <= '0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign code        = code_q;
    assign code_cnt    = code_cnt_q;
    assign digit_valid = digit_valid_q;
    assign multi_err   = multi_err_q;
    assign fail        = fail_q;
    assign timeout     = timeout_q;
    assign unlock      = state_q == OPEN;
    assign locked      = state_q == LOCK;
    assign state       = state_q;
endmodule

// File: tb/tb_sw_entry_ctrl.sv
// tb_sw_entry_ctrl: directed plus randomized switch stimulus checked every clock
// against an event-driven reference model of the entry sequencer.
module tb_sw_entry_ctrl;
    localparam int          BYTE  = 4;
    localparam int          DEB   = 16;
    localparam int          MAXF  = 3;
    localparam int          LOCKC = 64;
    localparam int          TOC   = 256;
    localparam logic [15:0] PW    = 16'h1234;
`ifdef ENTRY_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        clr = 1'b0;
    logic [9:0]  sw = '0;
    logic [15:0] code;
    logic [2:0]  code_cnt, state;
    logic        digit_valid, multi_err, unlock, fail, locked, timeout;

    sw_entry_ctrl dut (
        .clk(clk), .rst_n(rst_n), .sw(sw), .clr(clr),
        .code(code), .code_cnt(code_cnt), .digit_valid(digit_valid),
        .multi_err(multi_err), .unlock(unlock), .fail(fail),
        .locked(locked), .timeout(timeout), .state(state)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0, cyc = 0, dv_seen = 0;

    // reference model: states by number, times as absolute cycle stamps
    int          ms, mcnt, mfails, lock_end, last_dig, pend_due;
    logic [15:0] mcode;
    logic [9:0]  settled, pend_vec;
    bit          pend, clr_now, m_dv, m_me, m_fail, m_to;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    endtask

    task automatic model_edge();
        logic [9:0] r;
        int d;
        r = '0;
        d = 0;
        m_dv = 0; m_me = 0; m_fail = 0; m_to = 0;
        if (pend && cyc == pend_due) begin
            r = pend_vec & ~settled;
            settled = pend_vec;
            pend = 0;
        end
        for (int i = 0; i < 10; i++) if (r[i]) d = i;
        m_me = $countones(r) > 1;
        if (ms == 2) begin
            if (mcode == PW) begin
                ms = 3; mfails = 0;
            end else begin
                m_fail = 1; mfails++; mcode = 0; mcnt = 0;
                if (mfails == MAXF) begin ms = 4; lock_end = cyc + LOCKC; end
                else ms = 0;
            end
        end else if (ms == 4) begin
            if (cyc == lock_end) begin ms = 0; mfails = 0; end
        end else if (ms == 3) begin
            if (clr_now) begin ms = 0; mcode = 0; mcnt = 0; end
        end else begin
            if (clr_now) begin
                ms = 0; mcode = 0; mcnt = 0;
            end else if ($countones(r) == 1) begin
                mcode = {mcode[11:0], 4'(d)};
                mcnt++; m_dv = 1; last_dig = cyc;
                ms = (mcnt == BYTE) ? 2 : 1;
            end else if (TO_EN && ms == 1 && cyc - last_dig == TOC) begin
                m_to = 1; ms = 0; mcode = 0; mcnt = 0;
            end
        end
    endtask

    task automatic compare();
        dv_seen += int'(digit_valid);
        chk("state", 32'(state), 32'(ms));
        chk("code", 32'(code), 32'(mcode));
        chk("code_cnt", 32'(code_cnt), 32'(mcnt));
        chk("pulses dv/me/fail/to", {28'b0, digit_valid, multi_err, fail, timeout},
            {28'b0, m_dv, m_me, m_fail, m_to});
        chk("unlock/locked", {30'b0, unlock, locked}, {30'b0, ms == 3, ms == 4});
    endtask

    task automatic cycle(input logic [9:0] s, input logic c);
        if (s != sw) begin pend = 1; pend_vec = s; pend_due = cyc + DEB + 3; end
        sw = s; clr = c; clr_now = c;
        @(posedge clk);
        cyc++;
        @(negedge clk);
        model_edge();
        compare();
        clr = 1'b0;
    endtask

    task automatic hold(input int n);
        for (int i = 0; i < n; i++) cycle(sw, 1'b0);
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        ms = 0; mcnt = 0; mfails = 0; mcode = '0; settled = '0; pend = 0;
        m_dv = 0; m_me = 0; m_fail = 0; m_to = 0;
        for (int i = 0; i < n; i++) begin @(posedge clk); @(negedge clk); compare(); end
        rst_n = 1'b1;
        cyc = 0;
        pend = 1; pend_vec = sw; pend_due = DEB + 3;
    endtask

    // clr_at: call index (1-based after the raise) that carries clr, 0 for none
    task automatic enter_digit(input int d, input int clr_at);
        logic [9:0] v;
        if (sw[d]) begin v = sw; v[d] = 1'b0; cycle(v, 1'b0); hold(24); end
        v = sw; v[d] = 1'b1;
        for (int i = 1; i <= 25; i++) cycle(v, 1'(i == clr_at));
    endtask

    task automatic enter_pw();
        for (int i = BYTE - 1; i >= 0; i--) enter_digit(int'(PW[4*i +: 4]), 0);
    endtask

    initial begin
        #400000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat, dv0, a, b;
        logic [9:0] v;
        sw = 10'h3FF;
        @(negedge clk);
        do_reset(3);
        hold(25);
        cycle('0, 1'b0); hold(24);

        v = '0; v[3] = 1'b1;
        cycle(v, 1'b0); lat = 1;
        while (!digit_valid && lat < 40) begin cycle(v, 1'b0); lat++; end
        chk("latency", 32'(lat), 32'(DEB + 3));
        cycle(sw, 1'b1); hold(3);

        enter_pw();
        chk("open_unlock", 32'(unlock), 32'd1);
        chk("open_code", 32'(code), 32'h1234);
        cycle(sw, 1'b1); hold(2);
        chk("clr_open_state", 32'(state), 32'd0);

        for (int k = 0; k < MAXF; k++) for (int j = 0; j < BYTE; j++) enter_digit(0, 0);
        chk("lock_locked", 32'(locked), 32'd1);
        dv0 = dv_seen;
        enter_digit(5, 0);
        chk("lock_no_digit", 32'(dv_seen - dv0), 32'd0);
        hold(LOCKC);
        chk("lock_exit_state", 32'(state), 32'd0);
        enter_pw();
        chk("relock_unlock", 32'(unlock), 32'd1);
        cycle(sw, 1'b1); hold(2);

        cycle('0, 1'b0); hold(24);
        enter_digit(1, 0);
        v = sw; v[5] = 1'b1; v[7] = 1'b1;
        cycle(v, 1'b0); hold(24);
        chk("multi_cnt", 32'(code_cnt), 32'd1);
        dv0 = dv_seen;
        for (int i = 0; i < 20; i++) begin v = sw; v[2] = ~v[2]; cycle(v, 1'b0); hold(4); end
        hold(25);
        chk("bounce_no_digit", 32'(dv_seen - dv0), 32'd0);
        cycle(sw, 1'b1); hold(2);

        enter_digit(1, 0);
        enter_digit(2, 0);
        enter_digit(3, DEB + 3);
        chk("clr_mid_cnt", 32'(code_cnt), 32'd0);
        chk("clr_mid_state", 32'(state), 32'd0);

        enter_digit(9, 0);
        hold(300);
        chk("timeout_state", 32'(state), TO_EN ? 32'd0 : 32'd1);
        cycle(sw, 1'b1); hold(2);

        enter_digit(6, 0);
        do_reset(2);
        chk("rst_mid_cnt", 32'(code_cnt), 32'd0);
        hold(25);

        for (int it = 0; it < 150; it++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4: begin
                    a = ($urandom_range(0, 1) == 1 && mcnt < BYTE) ? int'(PW[4*(BYTE-1-mcnt) +: 4])
                                                                   : int'($urandom_range(0, 9));
                    enter_digit(a, 0);
                end
                5: begin
                    if ($countones(~sw) < 2) begin cycle('0, 1'b0); hold(24); end
                    do a = int'($urandom_range(0, 9)); while (sw[a]);
                    do b = int'($urandom_range(0, 9)); while (sw[b] || b == a);
                    v = sw; v[a] = 1'b1; v[b] = 1'b1;
                    cycle(v, 1'b0); hold(24);
                end
                6: begin cycle(sw & 10'($urandom), 1'b0); hold(24); end
                7: begin cycle(sw, 1'b1); hold(int'($urandom_range(0, 5))); end
                8: enter_digit(int'($urandom_range(0, 9)), DEB + 3);
                default: hold(int'($urandom_range(1, 300)));
            endcase
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
